// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared state encoding and default sizing for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int c_data_w = 16;
    localparam int c_addr_w = 8;
    localparam int c_depth  = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Streams a program image into instruction memory, verifies an
//               additive checksum, then releases the CPU via cpu_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import loader_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int ADDR_W = c_addr_w,
    parameter int DEPTH  = c_depth
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] exp_csum,
    input  logic              stop,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] csum
);

    localparam logic [ADDR_W:0] c_depth_max = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one       = (ADDR_W + 1)'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   w_len_clamped;
    logic [DATA_W-1:0] r_exp_csum;
    logic [DATA_W-1:0] r_csum;
    logic              r_cpu_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              w_hs;
    logic              w_last;
    logic              w_start_ok;

    assign s_ready       = (r_state == ST_LOAD);
    assign w_hs          = s_valid & s_ready;
    assign w_last        = w_hs && (r_cnt == (r_len - c_one));
    // stop has priority over start in ERROR
    assign w_start_ok    = start && ((r_state == ST_IDLE) ||
                                     ((r_state == ST_ERROR) && !stop));
    assign w_len_clamped = (len > c_depth_max) ? c_depth_max : len;

    assign imem_we    = w_hs;
    assign imem_waddr = w_hs ? r_cnt[ADDR_W-1:0] : '0;
    assign imem_wdata = w_hs ? s_data : '0;

    assign cpu_ready  = r_cpu_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign csum       = r_csum;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if ((r_state == ST_ERROR) && stop) begin
                    w_next_state = ST_IDLE;
                end else if (w_start_ok) begin
                    w_next_state = (w_len_clamped == '0) ? ST_CHECK : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_last) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_next_state = (r_csum == r_exp_csum) ? ST_RUN : ST_ERROR;
            end
            ST_RUN: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Status outputs are registered decodes of the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_exp_csum  <= '0;
            r_csum      <= '0;
            r_cpu_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cpu_ready <= (w_next_state == ST_RUN);
            r_busy      <= (w_next_state == ST_LOAD) || (w_next_state == ST_CHECK);
            r_err       <= (w_next_state == ST_ERROR);
            r_done      <= (w_next_state == ST_RUN) && (r_state != ST_RUN);
            if (w_start_ok) begin
                r_len      <= w_len_clamped;
                r_exp_csum <= exp_csum;
                r_cnt      <= '0;
                r_csum     <= '0;
            end else if (w_hs) begin
                r_cnt  <= r_cnt + c_one;
                r_csum <= r_csum + s_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Boot-time sequencer for the single-cycle processor. It streams a program image into instruction memory over a valid/ready word interface, then checks a 16-bit additive checksum. The CPU's `ready` input is held low until the image is loaded and verified, and is raised only after that. It sits between the external load port, the instruction-memory write port and the processor controller's `ready` input.

## Interface
Parameters:
- `DATA_W`, 16: instruction width.
- `ADDR_W`, 8: instruction-memory address width.
- `DEPTH`, 256: words in instruction memory; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a load; sampled in IDLE and ERROR only.
- `len`  in  ADDR_W+1  words to load; sampled with `start`.
- `exp_csum`  in  DATA_W  expected checksum; sampled with `start`.
- `stop`  in  1  leave RUN or ERROR and return to IDLE.
- `s_valid`  in  1  load word valid.
- `s_data`  in  DATA_W  load word.
- `s_ready`  out  1  loader accepts a word.
- `imem_we`  out  1  instruction-memory write enable.
- `imem_waddr`  out  ADDR_W  write address.
- `imem_wdata`  out  DATA_W  write data.
- `cpu_ready`  out  1  drives the controller's `ready`; high only in RUN.
- `busy`  out  1  high in LOAD or CHECK.
- `done`  out  1  one-cycle pulse on entry to RUN.
- `err`  out  1  high in ERROR.
- `csum`  out  DATA_W  running checksum.

## Operation
States are IDLE, LOAD, CHECK, RUN and ERROR.

- **Reset:**
  - State goes to IDLE.
  - Word counter, `csum`, latched `len` and latched `exp_csum` clear to 0.
  - All outputs are 0.
  - Reset takes effect asynchronously, including mid-load; `imem_we` drops immediately.
- **IDLE** (`start`=1):
  - Latch `min(len, DEPTH)` and `exp_csum`; clear the counter and `csum`.
  - Go to LOAD, or straight to CHECK if the clamped length is 0.
- **LOAD:**
  - `s_ready`=1.
  - A handshake is `s_valid & s_ready`. On each handshake:
    - `imem_we`=1, `imem_waddr`=counter[ADDR_W-1:0], `imem_wdata`=`s_data`. These are combinational in the handshake cycle.
    - Counter increments; `csum` ← (`csum` + `s_data`) mod 2^DATA_W.
  - The handshake with counter = len−1 moves the FSM to CHECK.
  - `start` is ignored. `stop` is ignored; only reset aborts a load.
- **CHECK** (one cycle, `s_ready`=0):
  - `csum` == latched `exp_csum` → RUN.
  - Otherwise → ERROR.
- **RUN:**
  - `cpu_ready`=1; `done`=1 in the first RUN cycle only.
  - `stop` → IDLE. `start` is ignored.
- **ERROR:**
  - `err`=1; `cpu_ready` stays 0.
  - `start` → restart, exactly as from IDLE.
  - `stop` → IDLE.
  - If `start` and `stop` are both high, `stop` wins.
- `csum` holds its value outside LOAD and is cleared only by `start` or reset.

## Timing
- `cpu_ready`, `busy`, `err` and `done` are registered decodes of state.
- `s_ready` and `imem_we` are combinational from state and `s_valid`.
- With `start` sampled at edge 0 and `s_valid` held high for N ≥ 1 words:
  - Handshakes occur in cycles 1..N.
  - CHECK occurs in cycle N+1.
  - RUN, `done` and `cpu_ready` rise in cycle N+2.
- With `len`=0: CHECK in cycle 1, RUN or ERROR in cycle 2.
- Gaps in `s_valid` stall the counter; there are no writes and `csum` is unchanged during a gap.
- Counter is ADDR_W+1 bits, so `len`=DEPTH loads addresses 0..DEPTH−1 without wrap.
- `cpu_ready` falls the cycle after `stop` is sampled in RUN.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum (IDLE, LOAD, CHECK, RUN, ERROR);
  - default `DATA_W`, `ADDR_W` and `DEPTH` constants.
- Single module with no sub-module. The FSM, counter and checksum accumulator are small enough to stay in one block.

## Test plan
- **Clean load:** `len`=3, data 0x1111, 0x2222, 0x3333, `exp_csum`=0x6666, `s_valid` held high → writes to addresses 0, 1, 2; `done` and `cpu_ready` rise in cycle 5; `err`=0.
- **Checksum mismatch:** same image with `exp_csum`=0x6667 → ERROR in cycle 5, `err`=1, `cpu_ready`=0. A following `start` with correct `exp_csum` → RUN.
- **Backpressure:** `len`=2, `s_valid` pattern 1,0,0,1 → exactly 2 writes; CHECK occurs 2 cycles later than the no-gap case; `csum` is unchanged during gaps.
- **Wrap and empty load:**
  - 0xFFFF then 0x0002 → `csum`=0x0001.
  - `len`=0 with `exp_csum`=0 → RUN in cycle 2 with no writes.
- **Reset mid-load:** deassert `rst_n` after 1 of 4 words → `imem_we`=0 immediately; state is IDLE with all outputs 0; `s_data` is ignored until the next `start`.
- **Stop handling:**
  - `stop` in RUN → `cpu_ready` falls next cycle; state is IDLE.
  - `start` in RUN or LOAD → ignored.
  - `start` and `stop` together in ERROR → IDLE.
